// File: rtl/prco_regfile_pkg.sv
// Shared PRCO constants: default datapath width, register count and the
// architectural stack/base pointer slots used by the register file.
package prco_regfile_pkg;

  localparam int PRCO_DATA_W = 16;
  localparam int PRCO_NREGS  = 8;
  localparam int REG_SP      = 7;
  localparam int REG_BP      = 6;
  localparam int PRCO_SP_RST = 'h00FF;

endpackage : prco_regfile_pkg

// File: rtl/prco_scoreboard.sv
// Pending-write scoreboard for the PRCO register file.
// One busy bit per register: set by an issue-time claim, cleared by the
// write-back that retires it. A same-cycle claim and retire of the same
// index leaves the bit set. q_waw flags a claim of an already-busy register.
module prco_scoreboard
  import prco_regfile_pkg::*;
#(
  parameter  int NREGS = PRCO_NREGS,
  localparam int SEL_W = $clog2(NREGS)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic             i_claim,
  input  logic [SEL_W-1:0] i_claim_sel,
  input  logic             i_we,
  input  logic [SEL_W-1:0] i_seld,
  output logic [NREGS-1:0] q_busy,
  output logic             q_waw
);

  logic [NREGS-1:0] w_busy_next;

  // Next busy vector: retire first, then claim, so a colliding claim wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first; without it a
    // missed branch would infer a latch.
    w_busy_next = q_busy;
    if (i_we)    w_busy_next[i_seld]      = 1'b0;
    if (i_claim) w_busy_next[i_claim_sel] = 1'b1;
  end

  // Busy bits and WAW pulse; everything freezes (pulse drops) when disabled.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      // NOTE: sequential state uses non-blocking assignments only, so all
      // flops sample pre-edge values regardless of block ordering.
      q_busy <= '0;
      q_waw  <= 1'b0;
    end else if (i_en) begin
      q_busy <= w_busy_next;
      q_waw  <= i_claim & q_busy[i_claim_sel];
    end else begin
      q_waw  <= 1'b0;
    end
  end

endmodule : prco_scoreboard

// File: rtl/prco_regfile.sv
// PRCO register file: NREGS x DATA_W flop storage, two registered read
// ports gated by a pending-write scoreboard, one write port.
// Optional macro PRCO_REGFILE_BYPASS_EN forwards same-cycle write data to
// matching read ports and lets that write resolve a busy hazard. Without
// it, reads see the pre-write value and a retiring busy register stalls
// one more cycle.
// Selects are exactly SEL_W bits and NREGS is a power of two, so every
// select value addresses a real register.
module prco_regfile
  import prco_regfile_pkg::*;
#(
  parameter  int          DATA_W = PRCO_DATA_W,
  parameter  int          NREGS  = PRCO_NREGS,
  parameter  int          SP_IDX = REG_SP,
  parameter  int          BP_IDX = REG_BP,
  parameter  int unsigned SP_RST = PRCO_SP_RST,
  localparam int          SEL_W  = $clog2(NREGS)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_en,
  input  logic              i_rd_req,
  input  logic [SEL_W-1:0]  i_sela,
  input  logic [SEL_W-1:0]  i_selb,
  output logic [DATA_W-1:0] q_data,
  output logic [DATA_W-1:0] q_datb,
  output logic              q_rd_valid,
  output logic              q_stall,
  input  logic              i_claim,
  input  logic [SEL_W-1:0]  i_claim_sel,
  input  logic              i_we,
  input  logic [SEL_W-1:0]  i_seld,
  input  logic [DATA_W-1:0] i_datd,
  output logic [NREGS-1:0]  q_busy,
  output logic              q_waw
);

  logic [DATA_W-1:0] r_regs [NREGS];

  logic              w_fwd_a;
  logic              w_fwd_b;
  logic [DATA_W-1:0] w_dat_a;
  logic [DATA_W-1:0] w_dat_b;
  logic              w_hazard;

  prco_scoreboard #(
    .NREGS (NREGS)
  ) u_scoreboard (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_en        (i_en),
    .i_claim     (i_claim),
    .i_claim_sel (i_claim_sel),
    .i_we        (i_we),
    .i_seld      (i_seld),
    .q_busy      (q_busy),
    .q_waw       (q_waw)
  );

`ifdef PRCO_REGFILE_BYPASS_EN
  assign w_fwd_a = i_we && (i_seld == i_sela);
  assign w_fwd_b = i_we && (i_seld == i_selb);
`else
  assign w_fwd_a = 1'b0;
  assign w_fwd_b = 1'b0;
`endif

  assign w_dat_a  = w_fwd_a ? i_datd : r_regs[i_sela];
  assign w_dat_b  = w_fwd_b ? i_datd : r_regs[i_selb];
  assign w_hazard = (q_busy[i_sela] & ~w_fwd_a) | (q_busy[i_selb] & ~w_fwd_b);

  // Storage: architectural reset values, write on enabled i_we.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      // NOTE: this array is flops, not a RAM macro, and SP has a non-zero
      // architectural reset value, so every entry is reset explicitly.
      // BP is tested first so it stays zero even if configured onto SP.
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= (i == BP_IDX) ? '0 :
                     (i == SP_IDX) ? DATA_W'(SP_RST) : '0;
      end
    end else if (i_en && i_we) begin
      r_regs[i_seld] <= i_datd;
    end
  end

  // Read port: capture on an unhazarded request, else flag the stall.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      q_data     <= '0;
      q_datb     <= '0;
      q_rd_valid <= 1'b0;
      q_stall    <= 1'b0;
    end else if (i_en) begin
      if (i_rd_req && !w_hazard) begin
        q_data     <= w_dat_a;
        q_datb     <= w_dat_b;
        q_rd_valid <= 1'b1;
        q_stall    <= 1'b0;
      end else if (i_rd_req) begin
        q_rd_valid <= 1'b0;
        q_stall    <= 1'b1;
      end else begin
        q_rd_valid <= 1'b0;
        q_stall    <= 1'b0;
      end
    end else begin
      q_rd_valid <= 1'b0;
    end
  end

endmodule : prco_regfile
